// File: rtl/plic_irq_gateway.sv
// plic_irq_gateway
//   Interrupt gateway between SoC interrupt producers and the PLIC source
//   inputs. Each raw line is mapped onto a fixed PLIC source index and turned
//   into a single-outstanding request that follows the claim/complete protocol.
//   Each source is either level- or edge-triggered, selected by EDGE_MASK.
//   Edge sources keep a saturating pending counter and a sticky overflow flag.
//
//   Source map: pbus_irq_i[0..3] -> 1..4 (GPIO-in, TIM0, TIM1, UART),
//               hls_irq_i -> 5, cdma_irq_i -> 6; all other indices unmapped.
//
//   Optional: define PLIC_IRQ_GATEWAY_SYNC_EN to pass every raw input through
//   a 2-flop synchronizer (raw-to-irq_src_o latency 3 cycles instead of 1).
//
// Ports
//   clk_i            system clock
//   rst_ni           synchronous active-low reset
//   pbus_irq_i       PBUS lines [0] GPIO-in, [1] TIM0, [2] TIM1, [3] UART
//   hls_irq_i        HLS core interrupt
//   cdma_irq_i       CDMA interrupt
//   claim_valid_i    PLIC claims source claim_id_i this cycle
//   claim_id_i       claimed source index
//   complete_valid_i PLIC completes source complete_id_i this cycle
//   complete_id_i    completed source index
//   irq_src_o        registered request vector (bit i = source i pending)
//   in_service_o     per-source in-service flags
//   overflow_o       sticky per-source edge-counter overflow flags
module plic_irq_gateway #(
    parameter int unsigned          NUM_SRC    = 32,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK  = '0,
    parameter int unsigned          PEND_CNT_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [3:0]         pbus_irq_i,
    input  logic               hls_irq_i,
    input  logic               cdma_irq_i,
    input  logic               claim_valid_i,
    input  logic [4:0]         claim_id_i,
    input  logic               complete_valid_i,
    input  logic [4:0]         complete_id_i,
    output logic [NUM_SRC-1:0] irq_src_o,
    output logic [NUM_SRC-1:0] in_service_o,
    output logic [NUM_SRC-1:0] overflow_o
);

    // Sources 1..6 are the only ones wired to a producer.
    localparam logic [NUM_SRC-1:0] MAP_MASK = NUM_SRC'(7'h7E);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_e;

    state_e                state_q [NUM_SRC];
    state_e                state_d [NUM_SRC];
    logic [PEND_CNT_W-1:0] cnt_q   [NUM_SRC];
    logic [PEND_CNT_W-1:0] cnt_d   [NUM_SRC];

    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] smp;
    logic [NUM_SRC-1:0] hist_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ovf_q, ovf_d;
    logic [NUM_SRC-1:0] irq_q, irq_d;
    logic [NUM_SRC-1:0] svc_q, svc_d;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] cmpl_hit;

    always_comb begin
        raw      = '0;
        raw[4:1] = pbus_irq_i;
        raw[5]   = hls_irq_i;
        raw[6]   = cdma_irq_i;
    end

`ifdef PLIC_IRQ_GATEWAY_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign smp = sync2_q;
`else
    assign smp = raw;
`endif

    assign rise = smp & ~hist_q;

    // A transaction is accepted only when it matches the source's current
    // state; this also resolves claim+complete on the same id in one cycle.
    always_comb begin
        claim_hit = '0;
        cmpl_hit  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            claim_hit[i] = MAP_MASK[i] && claim_valid_i &&
                           (claim_id_i == 5'(i)) && (state_q[i] == ST_PENDING);
            cmpl_hit[i]  = MAP_MASK[i] && complete_valid_i &&
                           (complete_id_i == 5'(i)) && (state_q[i] == ST_IN_SERVICE);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        irq_d = '0;
        svc_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (MAP_MASK[i]) begin
                if (EDGE_MASK[i]) begin
                    // Edge and claim together cancel out in the counter.
                    if (rise[i] && !claim_hit[i]) begin
                        if (cnt_q[i] == '1) begin
                            ovf_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end else if (!rise[i] && claim_hit[i]) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end

                    if (claim_hit[i]) begin
                        state_d[i] = ST_IN_SERVICE;
                    end else if (state_q[i] == ST_IN_SERVICE && !cmpl_hit[i]) begin
                        state_d[i] = ST_IN_SERVICE;
                    end else begin
                        state_d[i] = (cnt_d[i] != '0) ? ST_PENDING : ST_IDLE;
                    end
                end else begin
                    // Complete always returns to IDLE; a still-high line
                    // re-pends on the following cycle.
                    if (state_q[i] == ST_IN_SERVICE) begin
                        state_d[i] = cmpl_hit[i] ? ST_IDLE : ST_IN_SERVICE;
                    end else if (claim_hit[i]) begin
                        state_d[i] = ST_IN_SERVICE;
                    end else begin
                        state_d[i] = smp[i] ? ST_PENDING : ST_IDLE;
                    end
                end
            end
            irq_d[i] = (state_d[i] == ST_PENDING);
            svc_d[i] = (state_d[i] == ST_IN_SERVICE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= '0;
            ovf_q  <= '0;
            irq_q  <= '0;
            svc_q  <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            hist_q <= smp;
            ovf_q  <= ovf_d;
            irq_q  <= irq_d;
            svc_q  <= svc_d;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign irq_src_o    = irq_q;
    assign in_service_o = svc_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// tb_plic_irq_gateway
//   Self-checking bench for plic_irq_gateway. A cycle model predicts the
//   outputs for every driven cycle; predictions are queued at drive time and
//   compared after the following clock edge. Directed checks cover the
//   settled states of each scenario with fixed expected values.
//   Sources 2 (TIM0) and 6 (CDMA) are edge-triggered, the rest level.
module tb_plic_irq_gateway;

    localparam int          NUM_SRC    = 32;
    localparam logic [31:0] EDGE_MASK  = 32'h0000_0044;
    localparam int          PEND_CNT_W = 2;
    localparam int          CMAX       = 3;
`ifdef PLIC_IRQ_GATEWAY_SYNC_EN
    localparam int          SYNC_LAT   = 2;
`else
    localparam int          SYNC_LAT   = 0;
`endif

    logic        clk;
    logic        rst_ni;
    logic [3:0]  pbus_irq;
    logic        hls_irq;
    logic        cdma_irq;
    logic        claim_valid;
    logic [4:0]  claim_id;
    logic        complete_valid;
    logic [4:0]  complete_id;
    logic [31:0] irq_src_o;
    logic [31:0] in_service_o;
    logic [31:0] overflow_o;

    plic_irq_gateway #(
        .NUM_SRC    (NUM_SRC),
        .EDGE_MASK  (EDGE_MASK),
        .PEND_CNT_W (PEND_CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .pbus_irq_i       (pbus_irq),
        .hls_irq_i        (hls_irq),
        .cdma_irq_i       (cdma_irq),
        .claim_valid_i    (claim_valid),
        .claim_id_i       (claim_id),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id),
        .irq_src_o        (irq_src_o),
        .in_service_o     (in_service_o),
        .overflow_o       (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] irq;
        logic [31:0] svc;
        logic [31:0] ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: 0 idle, 1 pending, 2 in service
    int   m_st   [8];
    int   m_cnt  [8];
    logic m_ovf  [8];
    logic m_prev [8];
    logic [7:0] m_s1, m_s2;

    logic [3:0] cur_pb;
    logic       cur_h, cur_c;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_prev[i] = 1'b0;
        end
        m_s1 = '0;
        m_s2 = '0;
    endtask

    task automatic cyc(input logic rst, input logic [3:0] pb, input logic h, input logic c,
                       input logic cv, input logic [4:0] cid, input logic mv, input logic [4:0] mid);
        exp_t       e;
        logic [7:0] raw, smp;
        @(negedge clk);
        rst_ni = rst; pbus_irq = pb; hls_irq = h; cdma_irq = c;
        claim_valid = cv; claim_id = cid; complete_valid = mv; complete_id = mid;
        raw = {1'b0, c, h, pb, 1'b0};
        if (!rst) begin
            model_reset();
        end else begin
`ifdef PLIC_IRQ_GATEWAY_SYNC_EN
            smp = m_s2; m_s2 = m_s1; m_s1 = raw;
`else
            smp = raw;
`endif
            for (int i = 1; i <= 6; i++) begin
                logic cl, dn;
                cl = cv && (int'(cid) == i) && (m_st[i] == 1);
                dn = mv && (int'(mid) == i) && (m_st[i] == 2);
                if (EDGE_MASK[i]) begin
                    if (smp[i] && !m_prev[i]) begin
                        if (!cl) begin
                            if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
                            else m_cnt[i]++;
                        end
                    end else if (cl) begin
                        m_cnt[i]--;
                    end
                    m_prev[i] = smp[i];
                    if (cl) m_st[i] = 2;
                    else if (m_st[i] == 2 && !dn) m_st[i] = 2;
                    else m_st[i] = (m_cnt[i] != 0) ? 1 : 0;
                end else begin
                    if (m_st[i] == 2) m_st[i] = dn ? 0 : 2;
                    else m_st[i] = cl ? 2 : (smp[i] ? 1 : 0);
                end
            end
        end
        e.irq = '0; e.svc = '0; e.ovf = '0;
        for (int i = 1; i <= 6; i++) begin
            e.irq[i] = (m_st[i] == 1);
            e.svc[i] = (m_st[i] == 2);
            e.ovf[i] = m_ovf[i];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_irq", irq_src_o, e.irq);
        check_eq("sb_svc", in_service_o, e.svc);
        check_eq("sb_ovf", overflow_o, e.ovf);
    endtask

    task automatic tick(input logic cv, input logic [4:0] cid, input logic mv, input logic [4:0] mid);
        cyc(1'b1, cur_pb, cur_h, cur_c, cv, cid, mv, mid);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic claim(input logic [4:0] id);
        tick(1'b1, id, 1'b0, 5'd0);
    endtask

    task automatic complete(input logic [4:0] id);
        tick(1'b0, 5'd0, 1'b1, id);
    endtask

    initial begin
        rst_ni = 1'b0; pbus_irq = '0; hls_irq = 1'b0; cdma_irq = 1'b0;
        claim_valid = 1'b0; claim_id = '0; complete_valid = 1'b0; complete_id = '0;
        model_reset();

        // Reset hold with every raw line high
        cur_pb = 4'hF; cur_h = 1'b1; cur_c = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, cur_pb, cur_h, cur_c, 1'b0, 5'd0, 1'b0, 5'd0);
        check_eq("rst_irq", irq_src_o, 32'h0);
        check_eq("rst_svc", in_service_o, 32'h0);
        idle(3);
        check_eq("rel_irq", irq_src_o, 32'h0000_007E);
        cur_pb = 4'h0; cur_h = 1'b0; cur_c = 1'b0;
        idle(3);
        check_eq("withdraw_irq", irq_src_o, 32'h0000_0044);
        claim(5'd2); complete(5'd2); claim(5'd6); complete(5'd6);
        idle(1);
        check_eq("drain_irq", irq_src_o, 32'h0);

        // Level source UART
        cur_pb[3] = 1'b1;
        idle(3);
        check_eq("uart_pend", 32'(irq_src_o[4]), 32'd1);
        claim(5'd4);
        check_eq("uart_claim_irq", 32'(irq_src_o[4]), 32'd0);
        check_eq("uart_claim_svc", 32'(in_service_o[4]), 32'd1);
        complete(5'd4);
        idle(1);
        check_eq("uart_repend", 32'(irq_src_o[4]), 32'd1);
        cur_pb[3] = 1'b0;
        idle(3);
        check_eq("uart_drop", 32'(irq_src_o[4]), 32'd0);

        // Edge source CDMA: five pulses saturate the counter at 3
        for (int k = 0; k < 5; k++) begin
            cur_c = 1'b1; idle(1);
            cur_c = 1'b0; idle(1);
        end
        idle(3);
        check_eq("cdma_ovf", 32'(overflow_o[6]), 32'd1);
        check_eq("cdma_pend", 32'(irq_src_o[6]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            claim(5'd6);
            check_eq("cdma_claim_irq", 32'(irq_src_o[6]), 32'd0);
            complete(5'd6);
            idle(1);
            check_eq("cdma_after_pair", 32'(irq_src_o[6]), (k < 2) ? 32'd1 : 32'd0);
        end

        // Edge on TIM0 in the same sampled cycle as its claim
        cur_pb[1] = 1'b1; idle(1);
        cur_pb[1] = 1'b0; idle(3);
        check_eq("tim0_pend", 32'(irq_src_o[2]), 32'd1);
        cur_pb[1] = 1'b1;
        idle(SYNC_LAT);
        claim(5'd2);
        check_eq("tim0_sim_svc", 32'(in_service_o[2]), 32'd1);
        check_eq("tim0_sim_irq", 32'(irq_src_o[2]), 32'd0);
        cur_pb[1] = 1'b0;
        complete(5'd2);
        check_eq("tim0_repend", 32'(irq_src_o[2]), 32'd1);
        claim(5'd2); complete(5'd2);
        idle(2);
        check_eq("tim0_empty", 32'(irq_src_o[2]), 32'd0);

        // Ignored transactions
        cur_h = 1'b1;
        idle(3);
        claim(5'd0); claim(5'd9); complete(5'd5);
        check_eq("illegal_irq", irq_src_o, 32'h0000_0020);
        check_eq("illegal_svc", in_service_o, 32'h0);
        check_eq("illegal_ovf", overflow_o, 32'h0000_0040);

        // Reset in the middle of service
        cur_pb[2] = 1'b1;
        idle(3);
        claim(5'd3);
        check_eq("tim1_svc", in_service_o, 32'h0000_0008);
        cyc(1'b0, cur_pb, cur_h, cur_c, 1'b0, 5'd0, 1'b0, 5'd0);
        check_eq("midrst_irq", irq_src_o, 32'h0);
        check_eq("midrst_svc", in_service_o, 32'h0);
        check_eq("midrst_ovf", overflow_o, 32'h0);
        idle(3);
        check_eq("midrst_repend", irq_src_o, 32'h0000_0028);

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            logic [3:0] pb;
            logic       h, c, cv, mv, rst;
            logic [4:0] cid, mid;
            pb  = 4'($urandom);
            h   = 1'($urandom);
            c   = 1'($urandom);
            cv  = 1'($urandom);
            mv  = 1'($urandom);
            cid = 5'($urandom_range(0, 9));
            mid = 5'($urandom_range(0, 9));
            rst = ($urandom_range(0, 39) != 0);
            cyc(rst, pb, h, c, cv, cid, mv, mid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
